pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding logic and covers the hazards that forwarding cannot resolve:

- **Load-use:** inserts a one-cycle bubble.
- **Taken branch:** flushes the wrong-path instructions.
- **Multi-cycle mult/div:** holds EX for `MD_LATENCY` cycles.

It drives the PC/IF_ID write enables, the ID_EX/EX_MEM bubble controls and the EX hold. It also keeps saturating stall and flush event counters.

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencing for the 5-stage MIPS core. Covers
//               load-use bubbles, taken-branch flushes and multi-cycle
//               mult/div EX occupancy, plus saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_write_reg_addr,
  input  logic [4:0]       if_id_instr_rs,
  input  logic [4:0]       if_id_instr_rt,
  input  logic             if_id_uses_rt,
  input  logic             md_start,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             ex_mem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The RUN cycle counts as the first EX cycle and the done cycle as the
  // last, so the busy down-counter starts two below the total latency.
  localparam logic [7:0] C_MD_INIT = 8'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             w_lu;

  // Load-use: a load's destination feeds a source of the instruction behind it.
  assign w_lu = id_ex_mem_read && (id_ex_write_reg_addr != 5'd0) &&
                ((id_ex_write_reg_addr == if_id_instr_rs) ||
                 (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));

  // Next state and control outputs, combinational from state and inputs.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    md_done       = 1'b0;
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    if (!rst_n) begin
      // Keep the pipeline quiet and full of nops while in reset.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (md_start) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = MD_BUSY;
            md_cnt_d      = C_MD_INIT;
          end else if (w_lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          // Front end stays frozen through the done cycle as well.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (md_cnt_q != 8'd0) begin
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            md_cnt_d      = md_cnt_q - 8'd1;
          end else begin
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating event counters, qualified by the controls of this cycle.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != C_CNT_MAX)) stall_d = stall_q + 1'b1;
    if (if_id_flush && (flush_q != C_CNT_MAX)) flush_d = flush_q + 1'b1;
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= 8'd0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  // Observed state and counters read as idle/zero whenever reset is held.
  assign md_busy      = rst_n && (state_q == MD_BUSY);
  assign stall_cycles = rst_n ? stall_q : '0;
  assign flush_count  = rst_n ? flush_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl with a
//               queue of expected per-cycle controls and counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  // Control vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //                  ex_hold, ex_mem_bubble, md_busy, md_done}
  localparam logic [7:0] C_DEF  = 8'b1100_0000;
  localparam logic [7:0] C_LU   = 8'b0001_0000;
  localparam logic [7:0] C_BR   = 8'b1111_0000;
  localparam logic [7:0] C_MD1  = 8'b0000_1100;
  localparam logic [7:0] C_MDB  = 8'b0000_1110;
  localparam logic [7:0] C_MDD  = 8'b0000_0011;
  localparam logic [7:0] C_RST  = 8'b0011_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_ex_mem_read = 1'b0;
  logic [4:0]  id_ex_write_reg_addr = 5'd0;
  logic [4:0]  if_id_instr_rs = 5'd0;
  logic [4:0]  if_id_instr_rt = 5'd0;
  logic        if_id_uses_rt = 1'b0;
  logic        md_start = 1'b0;
  logic        branch_taken = 1'b0;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic        ex_hold, ex_mem_bubble, md_busy, md_done;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
  logic        s_ex_hold, s_ex_mem_bubble, s_md_busy, s_md_done;
  logic [3:0]  s_stall_cycles, s_flush_count;

  typedef struct {
    string       tag;
    logic [7:0]  ctrl;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [3:0]  stall_s;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_stall = 0;
  int          m_flush = 0;
  int          m_stall_s = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
    .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
    .if_id_uses_rt(if_id_uses_rt), .md_start(md_start), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
    .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
    .if_id_uses_rt(if_id_uses_rt), .md_start(md_start), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .ex_mem_bubble(s_ex_mem_bubble),
    .md_busy(s_md_busy), .md_done(s_md_done),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // One clock cycle: queue the expectation, compare at the falling edge,
  // advance the reference counters, then move just past the rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp_ctrl);
    exp_t e;
    logic [7:0] got;
    sb.push_back('{tag, exp_ctrl,
                   rst_n ? 16'(m_stall) : 16'd0,
                   rst_n ? 16'(m_flush) : 16'd0,
                   rst_n ? 4'(m_stall_s) : 4'd0});
    @(negedge clk);
    e = sb.pop_front();
    got = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_hold, ex_mem_bubble, md_busy, md_done};
    checks++;
    assert (got === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: got %b expected %b", e.tag, got, e.ctrl);
    end
    checks++;
    assert (stall_cycles === e.stall) else begin
      errors++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", e.tag, stall_cycles, e.stall);
    end
    checks++;
    assert (flush_count === e.flush) else begin
      errors++;
      $error("FAIL %s flush_count: got %0d expected %0d", e.tag, flush_count, e.flush);
    end
    checks++;
    assert (s_stall_cycles === e.stall_s) else begin
      errors++;
      $error("FAIL %s sat stall_cycles: got %0d expected %0d", e.tag, s_stall_cycles, e.stall_s);
    end
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
      m_stall_s = 0;
    end else begin
      if (!exp_ctrl[7] && m_stall < 65535) m_stall++;
      if (!exp_ctrl[7] && m_stall_s < 15) m_stall_s++;
      if (exp_ctrl[5] && m_flush < 65535) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic rd, input logic [4:0] wr, input logic [4:0] rs,
                          input logic [4:0] rt, input logic use_rt);
    id_ex_mem_read       = rd;
    id_ex_write_reg_addr = wr;
    if_id_instr_rs       = rs;
    if_id_instr_rt       = rt;
    if_id_uses_rt        = use_rt;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("reset0", C_RST);
    cyc("reset1", C_RST);
    rst_n = 1'b1;
    cyc("idle", C_DEF);

    // Load-use on rs, then the load moves on and the stall clears.
    set_load(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("lu_rs", C_LU);
    set_load(1'b0, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc("lu_rs_after", C_DEF);
    // Load to $0 never stalls.
    set_load(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("lu_r0", C_DEF);
    // rt match gated by if_id_uses_rt.
    set_load(1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    cyc("rt_unused", C_DEF);
    set_load(1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    cyc("rt_used", C_LU);
    set_load(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("rt_after", C_DEF);

    // Mult/div with md_start held; branch/lu during busy must be ignored.
    md_start = 1'b1;
    cyc("md_c1", C_MD1);
    for (int i = 2; i <= 7; i++) begin
      branch_taken = (i == 4);
      if (i == 5) set_load(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      else        set_load(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc($sformatf("md_c%0d", i), C_MDB);
    end
    branch_taken = 1'b0;
    cyc("md_c8", C_MDD);
    // Back-to-back: the next mult/div restarts immediately.
    cyc("md2_c1", C_MD1);
    cyc("md2_c2", C_MDB);
    cyc("md2_c3", C_MDB);
    // Reset in cycle 4 aborts the operation without md_done.
    rst_n = 1'b0;
    cyc("md2_rst", C_RST);
    rst_n = 1'b1;
    md_start = 1'b0;
    cyc("post_rst", C_DEF);
    cyc("post_rst2", C_DEF);

    // Branch wins over a simultaneous load-use.
    branch_taken = 1'b1;
    set_load(1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
    cyc("br_lu", C_BR);
    branch_taken = 1'b0;
    set_load(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("br_after", C_DEF);

    // Hold a load-use for 20 cycles; the 4-bit counter stops at 15.
    set_load(1'b1, 5'd6, 5'd0, 5'd6, 1'b1);
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), C_LU);
    set_load(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("sat_end", C_DEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
